regfile_dump: RTL and testbench

Debug readout engine that drives a register-file read port and streams a contiguous range of architectural registers out over a valid/ready interface. It sits between the debug/host link and one read port of the core register file. It requests a pipeline halt before the first read so the dumped snapshot is consistent, then releases the halt when the dump completes.

---
 rtl/regfile_dump.sv | 82 ++++++++
 tb/tb_regfile_dump.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
`timescale 1ns/1ps
// regfile_dump: halts the core, then streams a contiguous (wrapping) register range out over valid/ready
module regfile_dump #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ID_W-1:0]   start_id,
  input  logic [ID_W-1:0]   end_id,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic [ID_W-1:0]   rf_read_id,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, HALT_WAIT, READ, SEND, DONE} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, end_q;
  // rf_read_id is loaded only when entering READ so it stays put while waiting for the halt
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      end_q      <= '0;
      halt_req   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_id     <= '0;
      out_data   <= '0;
      rf_read_id <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ptr      <= start_id;
          end_q    <= end_id;
          halt_req <= 1'b1;
          busy     <= 1'b1;
          state    <= HALT_WAIT;
        end
        HALT_WAIT: if (halt_ack) begin
          rf_read_id <= ptr;
          state      <= READ;
        end
        READ: begin
          out_data  <= rf_read_data;
          out_id    <= ptr;
          out_last  <= ptr == end_q;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: if (out_ready) begin
          out_valid <= 1'b0;
          if (out_last) begin
            halt_req <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            ptr        <= ptr + 1'b1;
            rf_read_id <= ptr + 1'b1;
            state      <= READ;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
// tb_regfile_dump: randomized dumps against a queue scoreboard built from the range arithmetic
module tb_regfile_dump;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int N  = 32;
  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
  } word_t;
  logic clk = 0, rst = 1, start = 0, halt_ack = 0, out_ready = 0;
  logic [IW-1:0] start_id = '0, end_id = '0;
  logic halt_req, out_valid, out_last, busy, done;
  logic [IW-1:0] rf_read_id, out_id;
  logic [DW-1:0] rf_read_data, out_data;
  logic [DW-1:0] mem [N];
  int tests = 0, fails = 0, ready_pct = 100, done_cnt = 0;
  word_t q[$];
  word_t mw;
  logic hold_p = 0, last_p;
  logic [IW-1:0] id_p;
  logic [DW-1:0] data_p;

  always #5 clk = ~clk;
  assign rf_read_data = (rf_read_id == 0) ? '0 : mem[rf_read_id];

  regfile_dump #(.DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .start_id(start_id), .end_id(end_id),
    .halt_req(halt_req), .halt_ack(halt_ack), .rf_read_id(rf_read_id),
    .rf_read_data(rf_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_halt_req", {31'b0, halt_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_last", {31'b0, out_last}, 0);
    chk("rst_out_id", {27'b0, out_id}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_rf_read_id", {27'b0, rf_read_id}, 0);
  endtask

  // monitor: pops the scoreboard on each handshake and checks backpressure stability
  always @(negedge clk) begin
    if (hold_p) begin
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_id", {27'b0, out_id}, {27'b0, id_p});
      chk("hold_data", out_data, data_p);
      chk("hold_last", {31'b0, out_last}, {31'b0, last_p});
    end
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got id %0d data %0h, expected no word", out_id, out_data);
      end else begin
        mw = q.pop_front();
        chk("word_id", {27'b0, out_id}, {27'b0, mw.id});
        chk("word_data", out_data, mw.data);
        chk("word_last", {31'b0, out_last}, {31'b0, mw.last});
      end
    end
    if (!rst && done) done_cnt++;
    hold_p = !rst && out_valid && !out_ready;
    id_p   = out_id;
    data_p = out_data;
    last_p = out_last;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = ($urandom_range(99) < ready_pct);
  end

  task automatic run_dump(input int s, input int e, input int ack_delay, input bit mid_start, input bit timed);
    int n, k;
    logic [IW-1:0] rid;
    word_t w;
    n = (e - s + N) % N + 1;
    for (int i = 0; i < n; i++) begin
      w.id   = IW'((s + i) % N);
      w.data = (w.id == 0) ? '0 : mem[w.id];
      w.last = (i == n - 1);
      q.push_back(w);
    end
    tick();
    start = 1; start_id = IW'(s); end_id = IW'(e); halt_ack = (ack_delay == 0);
    tick();
    start = 0;
    k = 0;
    chk("halt_req_rise", {31'b0, halt_req}, 1);
    chk("busy_rise", {31'b0, busy}, 1);
    if (ack_delay > 0) begin
      rid = rf_read_id;
      repeat (ack_delay) begin
        chk("hw_halt_req", {31'b0, halt_req}, 1);
        chk("hw_no_valid", {31'b0, out_valid}, 0);
        chk("hw_read_id", {27'b0, rf_read_id}, {27'b0, rid});
        tick(); k++;
      end
      halt_ack = 1;
      tick(); k++;
      chk("ack_read_id", {27'b0, rf_read_id}, {27'b0, IW'(s)});
      chk("ack_no_valid", {31'b0, out_valid}, 0);
    end
    if (mid_start) begin
      tick(); k++;
      start = 1; start_id = '0; end_id = 5'd31;
      tick(); k++;
      start = 0;
    end
    while (!done && k < 4000) begin
      tick(); k++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, required a done pulse", k);
    end else if (timed) chk("done_latency", k, 2 * n + 1);
    chk("queue_drained", q.size(), 0);
    q.delete();
    tick();
    chk("post_busy", {31'b0, busy}, 0);
    chk("post_halt_req", {31'b0, halt_req}, 0);
    chk("post_done", {31'b0, done}, 0);
    halt_ack = 0;
  endtask

  initial begin
    int d0, b;
    for (int i = 0; i < N; i++) mem[i] = $urandom;
    repeat (3) tick();
    chk_reset();
    rst = 0;
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    run_dump(1, 3, 0, 0, 1);
    for (int i = 0; i < N; i++) mem[i] = 32'hA000 + i;
    run_dump(30, 29, 0, 0, 1);
    run_dump(4, 6, 10, 0, 0);
    ready_pct = 30;
    run_dump(5, 8, 0, 0, 0);
    ready_pct = 100;
    tick();
    run_dump(7, 7, 0, 1, 0);
    repeat (5) tick();
    chk("no_second_dump", {31'b0, busy}, 0);
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      ready_pct = $urandom_range(100, 20);
      run_dump($urandom_range(N - 1), $urandom_range(N - 1), $urandom_range(4), 0, 0);
    end
    ready_pct = 0;
    repeat (2) tick();
    start = 1; start_id = 5'd10; end_id = 5'd13; halt_ack = 1;
    tick();
    start = 0;
    b = 0;
    while (!out_valid && b < 20) begin
      tick(); b++;
    end
    chk("reset_reached_send", {31'b0, out_valid}, 1);
    d0 = done_cnt;
    rst = 1;
    tick();
    chk_reset();
    rst = 0;
    halt_ack = 0;
    repeat (3) tick();
    chk("reset_no_done", done_cnt, d0);
    chk("reset_idle", {31'b0, busy}, 0);
    ready_pct = 100;
    tick();
    run_dump(2, 5, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
